// File: rtl/shared_pkg.sv
// Shared types for the eyeriss DRAM link: transfer region encoding,
// responder FSM states and default region bases.
package shared_pkg;

  typedef enum logic [1:0] {
    IFMAP  = 2'd0,
    FILTER = 2'd1,
    BIAS   = 2'd2,
    PSUM   = 2'd3
  } data_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FWD,
    ST_BWD,
    ST_DONE
  } dram_resp_state_t;

  localparam logic [15:0] IFMAP_REGION_DEF  = 16'h0000;
  localparam logic [15:0] FILTER_REGION_DEF = 16'h4000;
  localparam logic [15:0] BIAS_REGION_DEF   = 16'h8000;
  localparam logic [15:0] PSUM_REGION_DEF   = 16'hC000;

endpackage

// File: rtl/dram_word_mem.sv
// Single-port synchronous word RAM with one-cycle read latency and no reset;
// benches preload and dump it through the mem array.
module dram_word_mem #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (en) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dram_link_responder.sv
// Off-chip end of the DRAM link: serves forward reads with one-cycle latency
// and absorbs backward writes into a behavioural word memory.
module dram_link_responder
  import shared_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 20,
  parameter int unsigned MEM_ADDR_WIDTH = 16,
  parameter logic [MEM_ADDR_WIDTH-1:0] IFMAP_REGION  = MEM_ADDR_WIDTH'(IFMAP_REGION_DEF),
  parameter logic [MEM_ADDR_WIDTH-1:0] FILTER_REGION = MEM_ADDR_WIDTH'(FILTER_REGION_DEF),
  parameter logic [MEM_ADDR_WIDTH-1:0] BIAS_REGION   = MEM_ADDR_WIDTH'(BIAS_REGION_DEF),
  parameter logic [MEM_ADDR_WIDTH-1:0] PSUM_REGION   = MEM_ADDR_WIDTH'(PSUM_REGION_DEF)
) (
  input  logic                  link_clk,
  input  logic                  reset,
  input  logic                  start_forward,
  input  logic                  start_backward,
  input  data_t                 transfer_type,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] words_num,
  input  logic                  re_from_dram,
  output logic [DATA_WIDTH-1:0] rdata_from_dram,
  output logic                  valid_from_dram,
  input  logic                  we_to_dram,
  input  logic [DATA_WIDTH-1:0] wdata_to_dram,
  output logic                  fwd_done,
  output logic                  bwd_done,
  output logic                  busy,
  output logic                  protocol_error
);

  dram_resp_state_t          state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0]     len_q, len_d;
  logic [ADDR_WIDTH-1:0]     cnt_q, cnt_d;
  logic                      rvalid_q, rvalid_d;
  logic                      bwd_q, bwd_d;
  logic                      err_q, err_d;

  logic                      mem_en, mem_we;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]     mem_rdata;
  logic [MEM_ADDR_WIDTH-1:0] region;

  always_comb begin
    region = IFMAP_REGION;
    case (transfer_type)
      FILTER:  region = FILTER_REGION;
      BIAS:    region = BIAS_REGION;
      PSUM:    region = PSUM_REGION;
      default: region = IFMAP_REGION;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    rvalid_d = 1'b0;
    bwd_d    = bwd_q;
    err_d    = err_q;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = base_q + MEM_ADDR_WIDTH'(cnt_q);

    if ((start_forward || start_backward) && state_q != ST_IDLE) err_d = 1'b1;
    if (re_from_dram && state_q != ST_FWD) err_d = 1'b1;
    if (we_to_dram && state_q != ST_BWD) err_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start_forward || start_backward) begin
          base_d = MEM_ADDR_WIDTH'(ADDR_WIDTH'(region) + base_addr);
          len_d  = words_num;
          cnt_d  = '0;
          bwd_d  = !start_forward;
          if (start_forward && start_backward) err_d = 1'b1;
          if (words_num == '0) state_d = ST_DONE;
          else                 state_d = start_forward ? ST_FWD : ST_BWD;
        end
      end
      ST_FWD: begin
        if (re_from_dram) begin
          if (cnt_q != len_q) begin
            mem_en   = 1'b1;
            rvalid_d = 1'b1;
            cnt_d    = cnt_q + ADDR_WIDTH'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        // Leave only once the word for the final request is on the bus.
        if (rvalid_q && cnt_q == len_q) state_d = ST_DONE;
      end
      ST_BWD: begin
        if (we_to_dram && cnt_q != len_q) begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + ADDR_WIDTH'(1);
          if (cnt_d == len_q) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge link_clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      bwd_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      bwd_q    <= bwd_d;
      err_q    <= err_d;
    end
  end

  dram_word_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(MEM_ADDR_WIDTH)
  ) u_mem (
    .clk  (link_clk),
    .en   (mem_en),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(wdata_to_dram),
    .rdata(mem_rdata)
  );

  // RAM output register is not reset, so gate it to keep rdata 0 when idle.
  assign rdata_from_dram = rvalid_q ? mem_rdata : '0;
  assign valid_from_dram = rvalid_q;
  assign busy            = (state_q != ST_IDLE);
  assign fwd_done        = (state_q == ST_DONE) && !bwd_q;
  assign bwd_done        = (state_q == ST_DONE) && bwd_q;
  assign protocol_error  = err_q;

endmodule

// File: tb/tb_dram_link_responder.sv
// Randomised scoreboard bench for dram_link_responder: a transfer-level
// reference model queues expected returns/done pulses, a monitor checks them.
module tb_dram_link_responder;
  import shared_pkg::*;

  localparam int INF = 32'h3fff_ffff;

  logic        link_clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_forward = 1'b0, start_backward = 1'b0;
  data_t       transfer_type = IFMAP;
  logic [19:0] base_addr = '0, words_num = '0;
  logic        re_from_dram = 1'b0, we_to_dram = 1'b0;
  logic [15:0] wdata_to_dram = '0;
  logic [15:0] rdata_from_dram;
  logic        valid_from_dram, fwd_done, bwd_done, busy, protocol_error;

  dram_link_responder #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(20),
    .MEM_ADDR_WIDTH(16)
  ) dut (
    .link_clk       (link_clk),
    .reset          (reset),
    .start_forward  (start_forward),
    .start_backward (start_backward),
    .transfer_type  (transfer_type),
    .base_addr      (base_addr),
    .words_num      (words_num),
    .re_from_dram   (re_from_dram),
    .rdata_from_dram(rdata_from_dram),
    .valid_from_dram(valid_from_dram),
    .we_to_dram     (we_to_dram),
    .wdata_to_dram  (wdata_to_dram),
    .fwd_done       (fwd_done),
    .bwd_done       (bwd_done),
    .busy           (busy),
    .protocol_error (protocol_error)
  );

  always #5 link_clk = ~link_clk;

  int cyc = 0;
  always @(posedge link_clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  typedef struct { int cyc; logic [15:0] data; } rd_exp_t;
  typedef struct { int cyc; bit bwd; } done_exp_t;
  rd_exp_t   rdq[$];
  done_exp_t dq[$];
  logic [15:0] ref_mem [65536];
  int written[$];

  // Transfer-level model state
  int m_mode = 0;      // 0 none, 1 forward, 2 backward
  int m_len = 0, m_cnt = 0, m_base = 0;
  int b_from = 0, b_to = -1;
  int err_from = INF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int region_of(data_t t);
    case (t)
      FILTER:  return 'h4000;
      BIAS:    return 'h8000;
      PSUM:    return 'hC000;
      default: return 'h0000;
    endcase
  endfunction

  function automatic void flag_err(int c);
    if (c + 1 < err_from) err_from = c + 1;
  endfunction

  function automatic void model_cycle(bit sf, bit sb, data_t tt, int ba, int wn,
                                      bit re, bit we, logic [15:0] wd);
    int c, a;
    c = cyc;
    if (re) begin
      if (m_mode == 1 && m_cnt < m_len) begin
        a = (m_base + m_cnt) % 65536;
        rdq.push_back('{c + 1, ref_mem[a]});
        m_cnt++;
        if (m_cnt == m_len) begin
          dq.push_back('{c + 2, 1'b0});
          b_to = c + 2;
          m_mode = 0;
        end
      end else flag_err(c);
    end
    if (we) begin
      if (m_mode == 2 && m_cnt < m_len) begin
        a = (m_base + m_cnt) % 65536;
        ref_mem[a] = wd;
        written.push_back(a);
        m_cnt++;
        if (m_cnt == m_len) begin
          dq.push_back('{c + 1, 1'b1});
          b_to = c + 1;
          m_mode = 0;
        end
      end else flag_err(c);
    end
    if (sf || sb) begin
      if (m_mode == 0 && c > b_to) begin
        m_base = (region_of(tt) + (ba & 'hFFFF)) % 65536;
        m_len  = wn;
        m_cnt  = 0;
        b_from = c;
        if (sf && sb) flag_err(c);
        if (wn == 0) begin
          dq.push_back('{c + 1, !sf});
          b_to = c + 1;
        end else begin
          m_mode = sf ? 1 : 2;
          b_to   = INF;
        end
      end else flag_err(c);
    end
  endfunction

  task automatic drive(bit sf, bit sb, data_t tt, int ba, int wn, bit re, bit we, logic [15:0] wd);
    start_forward  = sf;
    start_backward = sb;
    transfer_type  = tt;
    base_addr      = 20'(ba);
    words_num      = 20'(wn);
    re_from_dram   = re;
    we_to_dram     = we;
    wdata_to_dram  = wd;
    model_cycle(sf, sb, tt, ba, wn, re, we, wd);
    @(posedge link_clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, IFMAP, 0, 0, 0, 0, 16'h0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_mode != 0 || cyc <= b_to) && n < 200) begin
      idle(1);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL wait_idle cyc=%0d actual=busy required=idle", cyc);
    end
    idle(1);
  endtask

  task automatic mid_reset();
    reset          = 1'b1;
    start_forward  = 1'b0;
    start_backward = 1'b0;
    re_from_dram   = 1'b0;
    we_to_dram     = 1'b0;
    rdq.delete();
    dq.delete();
    m_mode   = 0;
    b_to     = -1;
    err_from = INF;
    #1;
    check("reset_valid", valid_from_dram, 0);
    check("reset_busy", busy, 0);
    check("reset_rdata", rdata_from_dram, 0);
    @(posedge link_clk);
    #1;
    reset = 1'b0;
  endtask

  // Scoreboard monitor: sample half a cycle away from the active edge.
  always @(negedge link_clk) begin
    if (rdq.size() > 0 && rdq[0].cyc == cyc) begin
      check("valid", valid_from_dram, 1);
      check("rdata", rdata_from_dram, rdq[0].data);
      void'(rdq.pop_front());
    end else begin
      check("no_valid", valid_from_dram, 0);
    end
    if (dq.size() > 0 && dq[0].cyc == cyc) begin
      check("fwd_done", fwd_done, !dq[0].bwd);
      check("bwd_done", bwd_done, dq[0].bwd);
      void'(dq.pop_front());
    end else begin
      check("no_done", {fwd_done, bwd_done}, 0);
    end
    check("busy", busy, (cyc > b_from && cyc <= b_to));
    check("protocol_error", protocol_error, (cyc >= err_from));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          pat [7];
    bit          fwd, go;
    data_t       tt;
    int          ba, wn, guard;
    logic [15:0] v;

    for (int i = 0; i < 65536; i++) begin
      v = 16'($urandom);
      ref_mem[i] = v;
      dut.u_mem.mem[i] = v;
    end
    for (int i = 0; i < 8; i++) begin
      ref_mem['h4010 + i] = 16'(i + 1);
      dut.u_mem.mem['h4010 + i] = 16'(i + 1);
    end

    @(posedge link_clk); #1;
    @(posedge link_clk); #1;
    check("rst_valid", valid_from_dram, 0);
    check("rst_rdata", rdata_from_dram, 0);
    check("rst_busy", busy, 0);
    check("rst_fwd_done", fwd_done, 0);
    check("rst_bwd_done", bwd_done, 0);
    check("rst_error", protocol_error, 0);
    reset = 1'b0;

    // Forward burst, FILTER region, re held high
    drive(1, 0, FILTER, 'h10, 8, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, 0, FILTER, 'h10, 8, 1, 0, 0);
    wait_idle();

    // Gapped forward
    pat = '{1, 0, 1, 1, 0, 1, 1};
    drive(1, 0, IFMAP, 0, 5, 0, 0, 0);
    for (int i = 0; i < 7; i++) drive(0, 0, IFMAP, 0, 5, pat[i], 0, 0);
    wait_idle();
    check("gapped_err", protocol_error, 0);

    // Backward burst with wrap
    drive(0, 1, PSUM, 'h3FFE, 4, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, PSUM, 'h3FFE, 4, 0, 1, 16'(16'hA0 + i));
    wait_idle();
    check("wr_fffe", dut.u_mem.mem['hFFFE], 16'hA0);
    check("wr_ffff", dut.u_mem.mem['hFFFF], 16'hA1);
    check("wr_0000", dut.u_mem.mem['h0000], 16'hA2);
    check("wr_0001", dut.u_mem.mem['h0001], 16'hA3);

    // Zero-length forward and backward
    drive(1, 0, BIAS, 'h123, 0, 0, 0, 0);
    wait_idle();
    drive(0, 1, BIAS, 'h123, 0, 0, 0, 0);
    wait_idle();

    // Random legal transfers
    for (int t = 0; t < 25; t++) begin
      fwd = 1'($urandom_range(0, 1));
      tt  = data_t'($urandom_range(0, 3));
      ba  = int'($urandom_range(0, 'hFFFFF));
      wn  = int'($urandom_range(0, 12));
      drive(fwd, !fwd, tt, ba, wn, 0, 0, 0);
      guard = 0;
      while (m_mode != 0 && guard < 400) begin
        go = ($urandom_range(0, 2) != 0);
        drive(0, 0, tt, ba, wn, fwd & go, !fwd & go, 16'($urandom));
        guard++;
      end
      wait_idle();
    end
    check("random_err", protocol_error, 0);

    // Excess re after the last word, in FWD, DONE and IDLE
    drive(1, 0, FILTER, 'h10, 2, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, FILTER, 'h10, 2, 1, 0, 0);
    wait_idle();
    check("excess_err", protocol_error, 1);

    // Reset in the middle of a forward burst
    drive(1, 0, FILTER, 'h10, 8, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, FILTER, 'h10, 8, 1, 0, 0);
    mid_reset();
    drive(1, 0, FILTER, 'h10, 2, 0, 0, 0);
    for (int i = 0; i < 2; i++) drive(0, 0, FILTER, 'h10, 2, 1, 0, 0);
    wait_idle();
    check("post_reset_err", protocol_error, 0);

    // Start while busy is ignored; transfer carries on
    drive(1, 0, IFMAP, 'h20, 3, 0, 0, 0);
    drive(0, 0, IFMAP, 'h20, 3, 1, 0, 0);
    drive(0, 1, PSUM, 0, 4, 1, 0, 0);
    drive(0, 0, IFMAP, 'h20, 3, 1, 0, 0);
    wait_idle();
    check("busy_start_err", protocol_error, 1);

    // Simultaneous starts: forward wins and error is raised
    mid_reset();
    drive(1, 1, FILTER, 'h10, 3, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, FILTER, 'h10, 3, 1, 0, 0);
    wait_idle();
    check("both_start_err", protocol_error, 1);

    idle(3);
    foreach (written[i]) check("mem_dump", dut.u_mem.mem[written[i]], ref_mem[written[i]]);
    check("rdq_empty", rdq.size(), 0);
    check("dq_empty", dq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dram_link_responder.md
Name: dram_link_responder

Overview:
- Off-chip end of the eyeriss DRAM link, clocked on link_clk.
- Answers the accelerator's forward transfers: on re_from_dram it returns words with valid_from_dram, one cycle later.
- Absorbs backward transfers: we_to_dram / wdata_to_dram writes go into a behavioural word memory.
- Used as the memory model in top-level benches, and as the RTL source for a later real DRAM bridge.

Parameters:
- DATA_WIDTH, 16, link word width; matches the GLB word width.
- ADDR_WIDTH, 20, width of base_addr and words_num.
- MEM_ADDR_WIDTH, 16, log2 of memory depth; physical addresses wrap modulo 2**MEM_ADDR_WIDTH.
- IFMAP_REGION, 16'h0000, region base for transfer_type IFMAP.
- FILTER_REGION, 16'h4000, region base for FILTER.
- BIAS_REGION, 16'h8000, region base for BIAS.
- PSUM_REGION, 16'hC000, region base for PSUM.

Ports:
- link_clk, in, 1: the single clock.
- reset, in, 1: asynchronous, active-high.
- start_forward, in, 1: one-cycle pulse that starts a DRAM->chip transfer.
- start_backward, in, 1: one-cycle pulse that starts a chip->DRAM transfer.
- transfer_type, in, 2: data_t (IFMAP/FILTER/BIAS/PSUM); selects the region.
- base_addr, in, ADDR_WIDTH: word offset inside the region.
- words_num, in, ADDR_WIDTH: transfer length in words.
- re_from_dram, in, 1: chip requests one word.
- rdata_from_dram, out, DATA_WIDTH: returned word.
- valid_from_dram, out, 1: rdata_from_dram is valid this cycle.
- we_to_dram, in, 1: chip writes one word.
- wdata_to_dram, in, DATA_WIDTH: write data.
- fwd_done, out, 1: one-cycle pulse after the last forward word is delivered.
- bwd_done, out, 1: one-cycle pulse after the last backward word is written.
- busy, out, 1: high while not IDLE.
- protocol_error, out, 1: sticky error flag, cleared only by reset.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters 0. Memory is never reset and keeps its contents across reset.
- Start latch: on an accepted start, latch phys_base = REGION[transfer_type] + base_addr[MEM_ADDR_WIDTH-1:0] and latch len = words_num.
- FSM states: IDLE, FWD, BWD, DONE.
- IDLE --start_forward--> FWD.
- IDLE --start_backward--> BWD.
- Both starts in the same cycle: take FWD and set protocol_error.
- len==0: go directly to DONE; the done pulse comes one cycle after the start.
- FWD, issue: while issued<len, a cycle with re_from_dram=1 reads mem[(phys_base+issued) mod depth] and increments issued.
- FWD, return: the next cycle drives valid_from_dram=1 with that data; fixed latency of 1. Back-to-back re yields back-to-back valid.
- FWD, excess requests: re with issued==len is ignored (no valid) and sets protocol_error.
- FWD exit: when the final valid is driven, go to DONE and assert fwd_done in the following cycle.
- BWD, write: while written<len, a cycle with we_to_dram=1 writes wdata to mem[(phys_base+written) mod depth] and increments written.
- BWD exit: the cycle after the write with written==len-1, go to DONE and assert bwd_done.
- DONE: pulse the matching done signal for exactly one cycle, then return to IDLE.
- Starts outside IDLE are ignored and set protocol_error.
- re_from_dram outside FWD and we_to_dram outside BWD are ignored and set protocol_error.
- Address arithmetic is modulo 2**MEM_ADDR_WIDTH; crossing a region boundary is legal and unflagged.
- Reset mid-transfer: outputs drop to 0 immediately (asynchronous) and the FSM returns to IDLE. Any in-flight read is discarded; words already written stay in memory.

Decomposition:
- The following go in shared_pkg: data_t encoding (IFMAP=0, FILTER=1, BIAS=2, PSUM=3), the dram_resp_state_t enum and the region-base defaults.
- Sub-module dram_word_mem: single-port synchronous RAM, 1-cycle read latency, no reset. Benches preload it and dump it hierarchically through its mem array.

Test Plan:
- Forward burst: preload mem[0x4010..0x4017] = 1..8; start_forward with type=FILTER, base_addr=0x10, words_num=8; re held high -> valid on 8 consecutive cycles starting 1 cycle after first re, data 1..8, fwd_done pulse 1 cycle after last valid, busy falls with it.
- Gapped forward: IFMAP, base 0, 5 words, re pattern 1,0,1,1,0,1,1 -> valid exactly one cycle after each of the 5 re highs; no valid on gap cycles; protocol_error stays 0.
- Backward burst: start_backward with PSUM, base 0x3FFE, 4 words of 0xA0..0xA3 -> written at 0xFFFE, 0xFFFF, 0x0000, 0x0001 (wrap); bwd_done pulses 1 cycle after 4th we.
- Zero length and error cases:
  - words_num=0 forward -> fwd_done 1 cycle after start, no valid.
  - Simultaneous start_forward+start_backward -> FWD entered, protocol_error=1.
  - Extra re after len words -> no valid, error stays 1.
- Reset mid-forward: assert reset after 3 of 8 words -> valid/busy 0 same cycle; after release, a new 2-word transfer completes normally and protocol_error=0.
